seg7_scan: RTL and testbench

- Consumes the 16-bit `y` debug word driven by PCPU (selected via `select_y`/`show_gr`) and shows it as four hex digits.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display on the board.
- Sits directly downstream of the PCPU `y` output in the board top level.
- Provides programmable refresh, anti-ghosting blanking, leading-zero suppression and per-digit decimal points.

---
 rtl/seg7_scan.sv | 136 +++++++++++++
 tb/tb_seg7_scan.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit common-anode seven-segment scanner with blanking and decimal points
module seg7_scan #(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   P_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0]   P_GUARD = PW'(GUARD);

  logic [15:0]   r_disp;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic [3:0]    w_nib;
  logic [3:0]    w_zero_up;
  logic          w_lz_blank;
  logic          w_dark;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  // Active-low hex glyph; bit 0 is segment a, bit 6 is segment g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Capture the display word; loading works even while scanning is paused.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_disp <= 16'h0000;
    end else if (load) begin
      r_disp <= value;
    end
  end

  // Slot prescaler and digit index; both freeze while enable is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (enable) begin
      if (r_presc == P_LAST) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      2'd0: w_nib = r_disp[3:0];
      2'd1: w_nib = r_disp[7:4];
      2'd2: w_nib = r_disp[11:8];
      default: w_nib = r_disp[15:12];
    endcase
  end

  // w_zero_up[i] is set when nibbles i..3 are all zero; digit 0 never blanks.
  always_comb begin
    w_zero_up    = 4'b0000;
    w_zero_up[3] = (r_disp[15:12] == 4'h0);
    w_zero_up[2] = (r_disp[11:8] == 4'h0) && w_zero_up[3];
    w_zero_up[1] = (r_disp[7:4] == 4'h0) && w_zero_up[2];
    w_zero_up[0] = 1'b0;
    w_lz_blank   = blank_lz && w_zero_up[r_idx];
  end

  // Next output values: dark during guard, pause or leading-zero blanking.
  always_comb begin
    w_dark = !enable || (r_presc < P_GUARD) || w_lz_blank;
    w_an   = 4'b1111;
    w_seg  = 7'h7F;
    w_dp   = 1'b1;
    if (!w_dark) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = hex_glyph(w_nib);
      w_dp  = ~dp_mask[r_idx];
    end
  end

  // Register the pin drivers so the display sees glitch-free levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized self-checking bench for seg7_scan
module tb_seg7_scan;

  localparam int DIV   = 4;
  localparam int GUARD = 1;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests;
  int fails;

  // Reference state: count of enabled cycles since reset and the held word.
  int          m_ticks;
  logic [15:0] m_disp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .value(value), .load(load),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int cur_pos();
    return m_ticks % DIV;
  endfunction

  function automatic int cur_dig();
    return (m_ticks / DIV) % 4;
  endfunction

  // Predict what the pins show after the next edge, then take that edge.
  task automatic step();
    int          p;
    int          d;
    logic [15:0] upper;
    logic [15:0] nib;
    bit          dark;
    p     = cur_pos();
    d     = cur_dig();
    upper = m_disp >> (4 * d);
    nib   = upper & 16'h000F;
    dark  = !enable || (p < GUARD) || (blank_lz && d != 0 && upper == 16'h0000);
    if (dark) begin
      e_an  = 4'b1111;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = 4'b1111;
      e_an[d] = 1'b0;
      e_seg = glyph[nib[3:0]];
      e_dp  = ~dp_mask[d];
    end
    @(posedge clock);
    if (enable) m_ticks = m_ticks + 1;
    if (load) m_disp = value;
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_ticks = 0;
    m_disp  = 16'h0000;
  endtask

  task automatic test_scan();
    value = 16'h1234; load = 1'b1; enable = 1'b1; blank_lz = 1'b0; dp_mask = 4'b0000;
    step();
    load = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL scan[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] words [2] = '{16'h00A0, 16'h0000};
    blank_lz = 1'b1;
    for (int w = 0; w < 2; w++) begin
      value = words[w]; load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        tests++;
        if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
          fails++;
          $display("FAIL lz_%h[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", words[w], k, an, seg, dp, e_an, e_seg, e_dp);
        end
      end
    end
    // Leading-zero blanking must also suppress decimal points on blanked digits.
    dp_mask = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL lz_dp[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
  endtask

  task automatic test_dp();
    value = 16'hFFFF; load = 1'b1; dp_mask = 4'b0101;
    step();
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL dp[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    dp_mask = 4'b0000;
  endtask

  task automatic test_enable_pause();
    int guard_cnt;
    value = 16'h5678; load = 1'b1;
    step();
    load = 1'b0;
    guard_cnt = 0;
    while (!(cur_dig() == 2 && cur_pos() == 2) && guard_cnt < 64) begin
      step();
      guard_cnt++;
    end
    tests++;
    if (guard_cnt >= 64) begin
      fails++;
      $display("FAIL pause_align: reference never reached digit 2 slot position 2, got %0d want <64", guard_cnt);
    end
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL pause[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL resume[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_mid_slot_load();
    int guard_cnt;
    guard_cnt = 0;
    while (!(cur_dig() == 1 && cur_pos() == 2) && guard_cnt < 64) begin
      step();
      guard_cnt++;
    end
    value = 16'h89AB; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL midload[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      enable   = ($urandom_range(0, 7) != 0);
      load     = ($urandom_range(0, 9) == 0);
      value    = 16'($urandom);
      if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
      blank_lz = 1'($urandom);
      dp_mask  = 4'($urandom);
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp} || $countones(~an) > 1) begin
        fails++;
        $display("FAIL random[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    enable = 1'b1; load = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000;
  endtask

  task automatic test_reset_mid();
    value = 16'hC3D2; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 6; k++) step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, dp);
    end
    @(posedge clock);
    #1;
    reset   = 1'b0;
    m_ticks = 0;
    m_disp  = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      step();
      tests++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        fails++;
        $display("FAIL after_reset[%0d]: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    m_ticks  = 0;
    m_disp   = 16'h0000;
    reset    = 1'b1;
    enable   = 1'b0;
    value    = 16'h0000;
    load     = 1'b0;
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    test_reset();
    test_scan();
    test_leading_zero();
    test_dp();
    test_enable_pause();
    test_mid_slot_load();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
